alu_sequencer: RTL and testbench

Initiator side of the ALU operand/result interface. Collects operand A, operand B and an opcode from board switches through a single "enter" key. Drives them to the registered ALU, waits out the ALU latency, and captures the 16-bit result into a holding register for the hex display. It also keeps a count of completed operations.

---
 rtl/alu_sequencer.sv | 68 ++++++
 tb/tb_alu_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: collects two operands and an opcode, then captures the registered ALU result
module alu_sequencer #(
  parameter int ALU_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  sw,
  input  logic [2:0]  op_sel,
  input  logic        enter,
  input  logic [15:0] alu_result,
  output logic [7:0]  operand_a,
  output logic [7:0]  operand_b,
  output logic [2:0]  op_code,
  output logic [15:0] result,
  output logic        result_valid,
  output logic        busy,
  output logic [1:0]  stage,
  output logic [7:0]  op_count
);
  localparam logic [1:0] LOAD_A = 2'd0;
  localparam logic [1:0] LOAD_B = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] SHOW   = 2'd3;
  logic [1:0] state;
  logic       enterQ;
  logic [3:0] waitCnt;
  logic       enterRise;
  assign enterRise = enter & ~enterQ;
  assign busy      = state == WAIT;
  assign stage     = state;
  // enterQ tracks in every state so a press during WAIT is consumed there
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= LOAD_A;
      enterQ       <= 1'b0;
      waitCnt      <= 4'd0;
      operand_a    <= 8'd0;
      operand_b    <= 8'd0;
      op_code      <= 3'd0;
      result       <= 16'd0;
      result_valid <= 1'b0;
      op_count     <= 8'd0;
    end else begin
      enterQ <= enter;
      case (state)
        LOAD_A: if (enterRise) begin
          operand_a    <= sw;
          result_valid <= 1'b0;
          state        <= LOAD_B;
        end
        LOAD_B: if (enterRise) begin
          operand_b <= sw;
          op_code   <= op_sel;
          waitCnt   <= 4'(ALU_LATENCY);
          state     <= WAIT;
        end
        WAIT: if (waitCnt != 4'd0) waitCnt <= waitCnt - 4'd1;
        else begin
          result       <= alu_result;
          result_valid <= 1'b1;
          op_count     <= op_count + 8'd1;
          state        <= SHOW;
        end
        default: if (enterRise) state <= LOAD_A;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: drives a latency-1 and a latency-3 sequencer against a behavioural registered ALU
module tb_alu_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  sw[2];
  logic [2:0]  opSel[2];
  logic        enter[2];
  logic [15:0] aluRes[2];
  logic [7:0]  opA[2], opB[2], cnt[2];
  logic [2:0]  opc[2];
  logic [15:0] res[2];
  logic        rv[2], bsy[2];
  logic [1:0]  stg[2];
  logic [15:0] pipe1;
  logic [15:0] pipe3[3];
  int          total = 0;
  int          bad = 0;
  int          expCount[2];

  always #5 clk = ~clk;

  alu_sequencer #(.ALU_LATENCY(1)) u1 (
    .clk(clk), .reset(reset), .sw(sw[0]), .op_sel(opSel[0]), .enter(enter[0]),
    .alu_result(aluRes[0]), .operand_a(opA[0]), .operand_b(opB[0]), .op_code(opc[0]),
    .result(res[0]), .result_valid(rv[0]), .busy(bsy[0]), .stage(stg[0]), .op_count(cnt[0]));

  alu_sequencer #(.ALU_LATENCY(3)) u3 (
    .clk(clk), .reset(reset), .sw(sw[1]), .op_sel(opSel[1]), .enter(enter[1]),
    .alu_result(aluRes[1]), .operand_a(opA[1]), .operand_b(opB[1]), .op_code(opc[1]),
    .result(res[1]), .result_valid(rv[1]), .busy(bsy[1]), .stage(stg[1]), .op_count(cnt[1]));

  function automatic logic [15:0] aluFn(logic [7:0] a, logic [7:0] b, logic [2:0] op);
    logic [15:0] wa, wb;
    wa = {8'd0, a};
    wb = {8'd0, b};
    case (op)
      3'd0: return wa + wb;
      3'd1: return wa - wb;
      3'd2: return wa & wb;
      3'd3: return wa | wb;
      3'd4: return wa ^ wb;
      3'd5: return wa * wb;
      3'd6: return wa << b[3:0];
      default: return wa >> b[3:0];
    endcase
  endfunction

  // the ALU the sequencer talks to: result valid LAT edges after its inputs settle
  always @(posedge clk) begin
    pipe1    <= aluFn(opA[0], opB[0], opc[0]);
    pipe3[0] <= aluFn(opA[1], opB[1], opc[1]);
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign aluRes[0] = pipe1;
  assign aluRes[1] = pipe3[2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, int d, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask

  task automatic doOp(int d, logic [7:0] a, logic [7:0] b, logic [2:0] op);
    int lat;
    logic [15:0] e;
    lat = d ? 3 : 1;
    e = aluFn(a, b, op);
    sw[d] = a; enter[d] = 1'b1; tick(); enter[d] = 1'b0; tick();
    chk("ldA_stage", d, stg[d], 1);
    chk("ldA_opA", d, opA[d], a);
    chk("ldA_rv", d, rv[d], 0);
    sw[d] = b; opSel[d] = op; enter[d] = 1'b1; tick(); enter[d] = 1'b0;
    chk("e0_stage", d, stg[d], 2);
    chk("e0_opB", d, opB[d], b);
    chk("e0_opc", d, opc[d], op);
    chk("e0_busy", d, bsy[d], 1);
    for (int k = 1; k <= lat; k++) begin
      tick();
      chk("wait_busy", d, bsy[d], 1);
      chk("wait_rv", d, rv[d], 0);
    end
    tick();
    expCount[d] = (expCount[d] + 1) % 256;
    chk("cap_stage", d, stg[d], 3);
    chk("cap_busy", d, bsy[d], 0);
    chk("cap_result", d, res[d], e);
    chk("cap_rv", d, rv[d], 1);
    chk("cap_count", d, cnt[d], expCount[d]);
    enter[d] = 1'b1; tick(); enter[d] = 1'b0; tick();
    chk("show_exit_stage", d, stg[d], 0);
    chk("show_exit_result", d, res[d], e);
    chk("show_exit_rv", d, rv[d], 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      sw[d] = 8'd0; opSel[d] = 3'd0; enter[d] = 1'b0; expCount[d] = 0;
    end
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk("rst_stage", d, stg[d], 0);
      chk("rst_opA", d, opA[d], 0);
      chk("rst_result", d, res[d], 0);
      chk("rst_rv", d, rv[d], 0);
      chk("rst_count", d, cnt[d], 0);
      chk("rst_busy", d, bsy[d], 0);
    end
    doOp(0, 8'h0F, 8'h03, 3'b000);
    doOp(0, 8'h03, 8'h05, 3'b001);
    doOp(0, 8'hFF, 8'hFF, 3'b101);
    doOp(0, 8'h81, 8'h04, 3'b110);
    doOp(1, 8'h10, 8'h20, 3'b000);
    doOp(1, 8'hC3, 8'h11, 3'b100);
    // held enter gives one transition; a press during WAIT is swallowed
    sw[0] = 8'h5A; enter[0] = 1'b1; tick();
    chk("hold_stage", 0, stg[0], 1);
    sw[0] = 8'h11;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("hold_stage", 0, stg[0], 1);
      chk("hold_opA", 0, opA[0], 8'h5A);
    end
    enter[0] = 1'b0; tick();
    sw[0] = 8'h22; opSel[0] = 3'b011; enter[0] = 1'b1; tick(); enter[0] = 1'b0;
    chk("wp_e0_stage", 0, stg[0], 2);
    tick();
    enter[0] = 1'b1; tick();
    expCount[0]++;
    chk("wp_cap_stage", 0, stg[0], 3);
    chk("wp_cap_result", 0, res[0], 16'h007A);
    chk("wp_cap_count", 0, cnt[0], expCount[0]);
    tick();
    chk("wp_consumed", 0, stg[0], 3);
    enter[0] = 1'b0; tick();
    enter[0] = 1'b1; tick(); enter[0] = 1'b0; tick();
    chk("wp_exit", 0, stg[0], 0);
    // reset in the middle of WAIT
    sw[0] = 8'h44; enter[0] = 1'b1; tick(); enter[0] = 1'b0; tick();
    sw[0] = 8'h55; opSel[0] = 3'b000; enter[0] = 1'b1; tick(); enter[0] = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    expCount[0] = 0; expCount[1] = 0;
    chk("mid_rst_stage", 0, stg[0], 0);
    chk("mid_rst_opA", 0, opA[0], 0);
    chk("mid_rst_opB", 0, opB[0], 0);
    chk("mid_rst_result", 0, res[0], 0);
    chk("mid_rst_rv", 0, rv[0], 0);
    chk("mid_rst_count", 0, cnt[0], 0);
    chk("mid_rst_busy", 0, bsy[0], 0);
    tick(); tick(); tick();
    chk("no_cap_rv", 0, rv[0], 0);
    chk("no_cap_result", 0, res[0], 0);
    chk("no_cap_stage", 0, stg[0], 0);
    doOp(0, 8'h12, 8'h34, 3'b000);
    for (int i = 0; i < 255; i++)
      doOp(0, 8'($urandom), 8'($urandom), 3'($urandom_range(7)));
    chk("wrap_count", 0, cnt[0], 0);
    for (int i = 0; i < 8; i++)
      doOp(1, 8'($urandom), 8'($urandom), 3'($urandom_range(7)));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
